// File: rtl/experiment_six_core_if.sv
`default_nettype none
// ============================================================================
// Module      : experiment_six_core_if
// Description : Tile wrapper pin bundle for the experiment-six pattern core.
//               Carries the global enable, the dedicated inputs/outputs and
//               the bidirectional pin triplet (in/out/oe).
//                 ena     : global enable (1 = run, 0 = freeze all state)
//                 ui_in   : [1:0] mode, [2] direction, [6:3] prescale N,
//                           [7] bidirectional pin drive enable
//                 uo_out  : current pattern state
//                 uio_in  : parallel load data
//                 uio_out : wrap counter (or parity + wrap[6:0])
//                 uio_oe  : bidirectional pin output enables
//               master drives the inputs (wrapper / bench), slave is the core.
// Revision    : 1.0 - initial release
// ============================================================================
interface experiment_six_core_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface
`default_nettype wire

// File: rtl/experiment_six_core.sv
`default_nettype none
// ============================================================================
// Module      : experiment_six_core
// Description : Configurable 8-bit pattern generator. A programmable
//               prescaler produces a step strobe; on each step the pattern
//               state is held, counted up/down, advanced as an 8-bit
//               maximal-length Fibonacci LFSR, or loaded from uio_in.
//               A second 8-bit counter records wrap events and is presented
//               on the bidirectional pins.
// Ports       : clk  - clock, all state on rising edge
//               rst  - asynchronous active-high reset
//               bus  - experiment_six_core_if.slave
//                      (ena, ui_in, uo_out, uio_in, uio_out, uio_oe)
// Parameters  : LFSR_SEED  - zero-substitute value and LFSR wrap reference
//               PRESCALE_W - prescaler select width, taken from ui_in[6:3]
//                            (must not exceed 4 with the 8-bit ui_in)
// Options     : EXP6_PARITY_OUT_EN - when defined, uio_out[7] carries the
//               XOR reduction of the state and uio_out[6:0] = wrap[6:0];
//               otherwise uio_out = wrap[7:0].
// Revision    : 1.0 - initial release
// ============================================================================
module experiment_six_core #(
    parameter logic [7:0] LFSR_SEED  = 8'h01,
    parameter int         PRESCALE_W = 4
) (
    input  wire                  clk,
    input  wire                  rst,
    experiment_six_core_if.slave bus
);

    localparam logic [1:0] c_MODE_HOLD  = 2'b00;
    localparam logic [1:0] c_MODE_COUNT = 2'b01;
    localparam logic [1:0] c_MODE_LFSR  = 2'b10;
    localparam logic [1:0] c_MODE_LOAD  = 2'b11;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [PRESCALE_W-1:0] r_pre;
    logic [7:0]            r_state;
    logic [7:0]            r_wrap;

    // ------------------------------------------------------------------------
    // Control decode from the dedicated inputs
    // ------------------------------------------------------------------------
    logic [1:0]            w_mode;
    logic                  w_dir_down;
    logic [PRESCALE_W-1:0] w_pre_n;
    logic                  w_drive_en;

    assign w_mode     = bus.ui_in[1:0];
    assign w_dir_down = bus.ui_in[2];
    assign w_pre_n    = bus.ui_in[3 +: PRESCALE_W];
    assign w_drive_en = bus.ui_in[7];

    // Using >= rather than == means lowering N below the current count
    // produces a step on the very next enabled cycle instead of waiting
    // for the prescaler to wrap through its full width.
    logic w_step;
    assign w_step = bus.ena && (r_pre >= w_pre_n);

    // ------------------------------------------------------------------------
    // Next-state and wrap-event computation
    // ------------------------------------------------------------------------
    logic       w_lfsr_fb;
    logic [7:0] w_next;
    logic       w_wrap_inc;

    // Taps 8,6,5,4 (1-based) map to bits 7,5,4,3.
    assign w_lfsr_fb = r_state[7] ^ r_state[5] ^ r_state[4] ^ r_state[3];

    always_comb begin
        w_next     = r_state;
        w_wrap_inc = 1'b0;
        case (w_mode)
            c_MODE_HOLD: begin
                w_next     = r_state;
                w_wrap_inc = 1'b0;
            end
            c_MODE_COUNT: begin
                if (w_dir_down) begin
                    w_next     = r_state - 8'd1;
                    w_wrap_inc = (r_state == 8'h00);
                end else begin
                    w_next     = r_state + 8'd1;
                    w_wrap_inc = (r_state == 8'hFF);
                end
            end
            c_MODE_LFSR: begin
                // All-zero is the lock-up state of an XOR LFSR; substitute
                // the seed so the sequence can always start. That step also
                // lands on the seed and therefore counts as a wrap.
                if (r_state == 8'h00) begin
                    w_next = LFSR_SEED;
                end else begin
                    w_next = {r_state[6:0], w_lfsr_fb};
                end
                w_wrap_inc = (w_next == LFSR_SEED);
            end
            c_MODE_LOAD: begin
                w_next     = bus.uio_in;
                w_wrap_inc = 1'b0;
            end
            default: begin
                w_next     = r_state;
                w_wrap_inc = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequential update; ena=0 freezes prescaler, state and wrap together.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre   <= '0;
            r_state <= 8'h00;
            r_wrap  <= 8'h00;
        end else if (bus.ena) begin
            if (w_step) begin
                r_pre   <= '0;
                r_state <= w_next;
                if (w_wrap_inc) begin
                    r_wrap <= r_wrap + 8'd1;
                end
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: driven straight from registers, oe straight from ui_in[7]
    // so it tracks the pin even while reset is held.
    // ------------------------------------------------------------------------
    assign bus.uo_out = r_state;
    assign bus.uio_oe = w_drive_en ? 8'hFF : 8'h00;

`ifdef EXP6_PARITY_OUT_EN
    logic w_unused_wrap_msb;
    assign w_unused_wrap_msb = r_wrap[7];
    assign bus.uio_out       = {^r_state, r_wrap[6:0]};
`else
    assign bus.uio_out = r_wrap;
`endif

endmodule
`default_nettype wire

// File: tb/tb_experiment_six_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_experiment_six_core
// Description : Self-checking bench for experiment_six_core. A table of
//               reset-relative vectors, hand-written multi-cycle sequences
//               (reset hold, enable freeze, prescaler retarget, async reset)
//               and a randomized run checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_experiment_six_core;

    localparam logic [7:0] c_SEED = 8'h01;

    logic clk;
    logic rst;

    experiment_six_core_if bus ();

    experiment_six_core #(
        .LFSR_SEED  (c_SEED),
        .PRESCALE_W (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    // Behavioural model state
    int m_state;
    int m_pre;
    int m_wrap;

    typedef struct {
        logic [7:0] ui;
        logic [7:0] uio;
        int         cycles;
        int         exp_state;
        int         exp_wrap;
        logic [7:0] exp_oe;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_uio(input int st, input int wr);
        logic [7:0] s;
        logic [7:0] w;
        s = st[7:0];
        w = wr[7:0];
`ifdef EXP6_PARITY_OUT_EN
        return int'({^s, w[6:0]});
`else
        return int'(w) + 0 * int'(s);
`endif
    endfunction

    // Maximal-length LFSR successor from the polynomial x^8+x^6+x^5+x^4+1
    function automatic int lfsr_next(input int s);
        int fb;
        fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
        return ((s << 1) & 255) | fb;
    endfunction

    task automatic model_clock(input logic en, input logic [7:0] ui, input logic [7:0] ld);
        int n;
        int mode;
        int nxt;
        if (!en) return;
        n    = (int'(ui) >> 3) & 15;
        mode = int'(ui) & 3;
        if (m_pre < n) begin
            m_pre = m_pre + 1;
            return;
        end
        m_pre = 0;
        case (mode)
            1: begin
                if (ui[2]) begin
                    if (m_state == 0) m_wrap = m_wrap + 1;
                    m_state = (m_state + 255) % 256;
                end else begin
                    if (m_state == 255) m_wrap = m_wrap + 1;
                    m_state = (m_state + 1) % 256;
                end
            end
            2: begin
                nxt = (m_state == 0) ? int'(c_SEED) : lfsr_next(m_state);
                if (nxt == int'(c_SEED)) m_wrap = m_wrap + 1;
                m_state = nxt;
            end
            3: m_state = int'(ld);
            default: ;
        endcase
        m_wrap = m_wrap % 256;
    endtask

    // Reset for two edges, then release at a falling edge with new inputs.
    task automatic do_reset(input logic [7:0] ui, input logic [7:0] ld);
        @(negedge clk);
        rst        = 1'b1;
        bus.ena    = 1'b1;
        bus.ui_in  = ui;
        bus.uio_in = ld;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        m_state = 0;
        m_pre   = 0;
        m_wrap  = 0;
    endtask

    task automatic check_outputs(input string tag, input int st, input int wr, input logic [7:0] oe);
        check({tag, ".uo_out"},  int'(bus.uo_out),  st);
        check({tag, ".uio_out"}, int'(bus.uio_out), exp_uio(st, wr));
        check({tag, ".uio_oe"},  int'(bus.uio_oe),  int'(oe));
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h01;
        bus.uio_in = 8'h00;

        //               ui     uio    cyc  state  wrap  oe
        vecs[0] = '{8'h01, 8'h00,   5, 8'h05, 0, 8'h00}; // count up
        vecs[1] = '{8'h0D, 8'h00,   4, 8'hFE, 1, 8'h00}; // down, N=1
        vecs[2] = '{8'h02, 8'h00,   5, 8'h11, 1, 8'h00}; // LFSR 01,02,04,08,11
        vecs[3] = '{8'h83, 8'hA5,   1, 8'hA5, 0, 8'hFF}; // load + drive
        vecs[4] = '{8'h01, 8'h00, 256, 8'h00, 1, 8'h00}; // up wrap
        vecs[5] = '{8'h00, 8'h00,   7, 8'h00, 0, 8'h00}; // hold
        vecs[6] = '{8'h79, 8'h00,  32, 8'h02, 0, 8'h00}; // N=15
        vecs[7] = '{8'h02, 8'h00, 256, 8'h01, 2, 8'h00}; // LFSR full period
        vecs[8] = '{8'h05, 8'h00,   3, 8'hFD, 1, 8'h00}; // down, N=0
        vecs[9] = '{8'h03, 8'h3C,   1, 8'h3C, 0, 8'h00}; // load, no drive

        // Reset hold: outputs stay cleared while rst is high.
        @(negedge clk);
        rst       = 1'b1;
        bus.ui_in = 8'h01;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_outputs("reset_hold", 0, 0, 8'h00);
        end

        // Table vectors
        for (int v = 0; v < 10; v++) begin
            do_reset(vecs[v].ui, vecs[v].uio);
            repeat (vecs[v].cycles) @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", v), vecs[v].exp_state, vecs[v].exp_wrap, vecs[v].exp_oe);
        end

        // Enable freeze with N=1: pre must freeze too, else a step would leak.
        do_reset(8'h09, 8'h00);
        repeat (5) @(posedge clk);
        #1;
        check_outputs("freeze_pre", 2, 0, 8'h00);
        @(negedge clk);
        bus.ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("freeze.uo_out", int'(bus.uo_out), 2);
        end
        @(negedge clk);
        bus.ena = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("freeze_resume", 3, 0, 8'h00);

        // Lowering N below the running prescale count steps immediately.
        do_reset(8'h79, 8'h00);
        repeat (5) @(posedge clk);
        #1;
        check("retarget_pre.uo_out", int'(bus.uo_out), 0);
        @(negedge clk);
        bus.ui_in = 8'h11;
        @(posedge clk);
        #1;
        check("retarget_post.uo_out", int'(bus.uo_out), 1);

        // Mode change preserves state: count to 3, then LFSR from 3.
        do_reset(8'h01, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.ui_in = 8'h02;
        @(posedge clk);
        #1;
        check("mode_change.uo_out", int'(bus.uo_out), 6);

        // Async reset between edges, with drive enable on.
        do_reset(8'h81, 8'h00);
        repeat (20) @(posedge clk);
        #2;
        check("pre_async.uo_out", int'(bus.uo_out), 20);
        rst = 1'b1;
        #1;
        check_outputs("async_rst", 0, 0, 8'hFF);

        // Randomized run against the model
        do_reset(8'h01, 8'h00);
        for (int c = 0; c < 4000; c++) begin
            logic       en;
            logic [7:0] ui;
            logic [7:0] ld;
            en = ($urandom_range(0, 7) != 0);
            ui = 8'($urandom);
            if ($urandom_range(0, 3) != 0) ui[6:3] = 4'($urandom_range(0, 2));
            // Keep loads rare so LFSR and counter runs get long enough to wrap.
            if (ui[1:0] == 2'b11 && $urandom_range(0, 7) != 0) ui[1:0] = 2'b10;
            ld = 8'($urandom);
            @(negedge clk);
            bus.ena    = en;
            bus.ui_in  = ui;
            bus.uio_in = ld;
            @(posedge clk);
            model_clock(en, ui, ld);
            #1;
            check_outputs("rand", m_state, m_wrap, ui[7] ? 8'hFF : 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/experiment_six_core.md
Name: experiment_six_core

Overview:
- Configurable 8-bit pattern generator: the core of the experiment-six tile, sitting behind the standard tile wrapper pins (ui_in/uo_out/uio_*).
- Modes: hold, up/down counter, maximal-length LFSR, parallel load from uio_in.
- Step rate comes from a programmable prescaler.
- A second 8-bit counter records wrap events and can drive the bidirectional pins.

Parameters:
- LFSR_SEED, 8'h01: value substituted when LFSR mode sees state 0; also the wrap reference in LFSR mode.
- PRESCALE_W, 4: prescaler select width (ui_in[6:3]).

Ports:
- clk, input, 1: single clock; all state on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- ena, input, 1: global enable; 0 freezes all state (prescaler, state, wrap counter).
- ui_in, input, 8: [1:0] mode, [2] count direction, [6:3] prescale N, [7] uio drive enable.
- uo_out, output, 8: current pattern state.
- uio_in, input, 8: load data for mode 11.
- uio_out, output, 8: wrap counter.
- uio_oe, output, 8: output enables for uio pins.

Behaviour:
- Reset (async assert, sync release on clk edges after deassert): state=8'h00, pre=0, wrap=8'h00. Hence uo_out=0 and uio_out=0. uio_oe follows ui_in[7] combinationally, including during reset.
- Prescaler:
  - pre counts 0..N with N=ui_in[6:3].
  - step=1 on a cycle where ena=1 and pre>=N; that edge sets pre<=0.
  - Otherwise, when ena=1, pre<=pre+1.
  - N=0 steps every enabled clock; N=15 steps every 16th.
  - Lowering N below the current pre steps on the next enabled cycle.
- On a step edge, by mode (ui_in[1:0] sampled that cycle):
  - 00 hold: state unchanged.
  - 01 counter:
    - ui_in[2]=0: state+1 mod 256. 8'hFF->8'h00 increments wrap.
    - ui_in[2]=1: state-1 mod 256. 8'h00->8'hFF increments wrap.
  - 10 LFSR:
    - Fibonacci, taps 8,6,5,4: next={state[6:0], state[7]^state[5]^state[4]^state[3]}.
    - If state==0, next=LFSR_SEED (no lock-up).
    - wrap increments when the computed next equals LFSR_SEED. The zero-substitution step also counts.
    - Period 255.
  - 11 load: state<=uio_in; wrap unchanged.
- Mode changes take effect on the next step; state is preserved across mode changes.
- wrap is an 8-bit counter that rolls over 255->0 silently.
- uo_out=state, uio_out=wrap, both registered (zero combinational latency from state regs).
- uio_oe = ui_in[7] ? 8'hFF : 8'h00.
- ena=0 holds pre, state and wrap; outputs keep their last values.
- Reset mid-operation clears everything immediately (asynchronous).

Optional Feature:
- Macro: EXP6_PARITY_OUT_EN.
- Defined: uio_out[7] = even parity (XOR reduction) of state; uio_out[6:0] = wrap[6:0].
- Undefined: uio_out = wrap[7:0] as specified above.

Test Plan:
- Reset: rst=1 for 10 clk with ui_in=8'h01 -> uo_out=0, uio_out=0, uio_oe=0 throughout.
- Count up: ui_in=8'h01, ena=1, release rst, 5 clks -> uo_out=5. After 256 total steps -> uo_out=0, uio_out=1.
- Down + prescale: ui_in=8'h0D (down, N=1) from reset, 4 clks -> uo_out=8'hFE, uio_out=1.
- LFSR: ui_in=8'h02 from reset -> uo_out sequence 01,02,04,08,11. After 255 further steps, state returns to 01 with wrap incremented.
- Load + drive: ui_in=8'h83, uio_in=8'hA5, 1 clk -> uo_out=8'hA5, uio_oe=8'hFF.
- Enable/reset mid-run: ena=0 for 10 clks in count mode -> uo_out frozen. Assert rst asynchronously between edges -> uo_out=0 immediately.
